root_norm_sched: RTL and testbench
==================================

Name: root_norm_sched

Overview:
- Round-robin scheduler that shares one iterative square-root engine among NUM_REQ requesters in the normalization path.
- Each requester presents a sum of squares and receives floor(sqrt) back, tagged with its requester ID.
- Replaces per-channel combinational roots with one engine that retires one digit pair per cycle.
- Sits between the sum-of-squares accumulators and the descriptor normalization divider.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 32, radicand width; must be even.
- RES_W, DATA_W/2, result width (localparam, derived).
- ID_W, clog2(NUM_REQ), requester ID width (localparam, derived).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- req  in  NUM_REQ  per-requester level request.
- req_data  in  NUM_REQ*DATA_W  packed radicands; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.
- res_data  out  RES_W  floor(sqrt(radicand)).
- res_id  out  ID_W  index of the granted requester.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge) returns these to 0: gnt, res_valid, res_data, res_id, busy, state=IDLE, rr_ptr (priority to requester 0). Reset aborts any in-flight operation; no result is produced for it.
- IDLE, when any req bit is 1:
  - Grant the first set req[i] scanning from rr_ptr upward with wrap-around.
  - gnt[i]=1 for exactly this cycle.
  - Latch m=req_data[i], res=0, bit=1<<(DATA_W-2), id=i, cnt=RES_W.
  - Next state CALC. rr_ptr=(i+1) mod NUM_REQ.
- CALC, one iteration per cycle:
  - If m >= res+bit: m=m-(res+bit) and res=(res>>1)+bit.
  - Otherwise: res=res>>1.
  - Then bit=bit>>2 and cnt=cnt-1.
  - When cnt reaches 0 after exactly RES_W iterations, go to DONE.
  - Internal arithmetic is DATA_W bits; no intermediate exceeds DATA_W bits.
- DONE:
  - res_valid=1; res_data and res_id are stable while res_valid=1.
  - On res_valid & res_ready: next cycle IDLE and res_valid=0.
  - If res_ready stays low, hold indefinitely; no new grant is issued while held.
- Latency: gnt at cycle T; res_valid first high at T+RES_W+1 (T+17 by default).
  - Minimum initiation interval is RES_W+2 cycles (18) with res_ready tied high.
- Requester protocol:
  - req_data[i] must be stable while req[i]=1 and is sampled only in the grant cycle.
  - The requester drops req[i] the cycle after gnt[i]. A req[i] still high two cycles after gnt is a new request.
  - Dropping req[i] before grant is legal: no grant, no result.
- Simultaneous requests: strict round-robin. No requester waits more than NUM_REQ-1 grants.
- Boundary values: radicand 0 gives 0; all-ones gives all-ones in RES_W bits (0xFFFF); perfect squares are exact; non-squares truncate toward zero.
- busy: 1 in CALC and DONE, 0 in IDLE. A grant cycle is IDLE, so busy is still 0 in it.

Decomposition:
- Shared package (norm_pkg):
  - State enum {IDLE, CALC, DONE}.
  - DATA_W/RES_W defaults.
  - Function clog2.
- Sub-module root_iter_step: purely combinational single iteration.
  - Inputs m, res, bit; outputs m_next, res_next.
  - Parameterized by DATA_W; reused by the future pipelined variant.
- Scheduler FSM, round-robin pointer and output registers stay in root_norm_sched.

Test Plan:
- Single request: req[2] with data 1000000 -> gnt=4'b0100 for one cycle; res_valid 17 cycles later with res_data=1000 and res_id=2.
- Boundary values, one at a time on req[0]: 0->0, 1->1, 2->1, 15->3, 16->4, 65535->255, 0xFFFFFFFF->0xFFFF.
- All four requesters held high from reset, res_ready=1:
  - Grant order 0,1,2,3,0 with each grant 18 cycles apart.
  - Each res_id matches its grant.
  - Data {4,9,25,49} gives results {2,3,5,7}.
- Backpressure: res_ready=0 for 10 cycles after res_valid -> res_valid and res_data hold, busy=1, no gnt; grant to the next requester follows one cycle after acceptance.
- Reset mid-CALC: drop rst_n at gnt+5 -> all outputs 0 the next cycle; no res_valid; first post-reset grant goes to requester 0.
- Withdrawn request: req[1] raised then dropped while the engine is busy, req[3] high -> only gnt[3] is issued; no result carries id 1.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared types and helpers for the normalization-path square-root scheduler.
package norm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_RES_W  = DEF_DATA_W / 2;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/root_iter_step.sv
// One digit-pair step of the bitwise integer square root, purely combinational.
module root_iter_step
    import norm_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] m,
    input  logic [DATA_W-1:0] res,
    input  logic [DATA_W-1:0] bitpos,
    output logic [DATA_W-1:0] m_next,
    output logic [DATA_W-1:0] res_next
);

    logic [DATA_W-1:0] trial;

    always_comb begin
        trial = res + bitpos;
        if (m >= trial) begin
            m_next   = m - trial;
            res_next = (res >> 1) + bitpos;
        end else begin
            m_next   = m;
            res_next = res >> 1;
        end
    end

endmodule

// File: rtl/root_norm_sched.sv
// Round-robin arbiter sharing one iterative square-root engine among NUM_REQ requesters.
// Results are held in DONE until the downstream divider accepts them.
module root_norm_sched
    import norm_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  DATA_W  = DEF_DATA_W,
    localparam int RES_W   = DATA_W / 2,
    localparam int ID_W    = clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [RES_W-1:0]          res_data,
    output logic [ID_W-1:0]           res_id,
    output logic                      busy
);

    localparam int CNT_W = clog2(RES_W + 1);

    state_t            state, state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_valid;
    logic [DATA_W-1:0] pick_data;
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] m_q, res_q, bit_q;
    logic [DATA_W-1:0] m_next, res_next;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_iter;

    root_iter_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .m        (m_q),
        .res      (res_q),
        .bitpos   (bit_q),
        .m_next   (m_next),
        .res_next (res_next)
    );

    // First asserted request at or after rr_ptr, wrapping around.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = ID_W'(idx);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        pick_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_idx == ID_W'(k)) begin
                pick_data = req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign last_iter = (cnt_q == CNT_W'(1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant is a Mealy pulse in IDLE, suppressed while reset is asserted.
    always_comb begin
        state_next = state;
        gnt        = '0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = CALC;
                    if (rst_n) begin
                        gnt = NUM_REQ'(1) << pick_idx;
                    end
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            id_q      <= '0;
            m_q       <= '0;
            res_q     <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        m_q    <= pick_data;
                        res_q  <= '0;
                        bit_q  <= DATA_W'(1) << (DATA_W - 2);
                        id_q   <= pick_idx;
                        cnt_q  <= CNT_W'(RES_W);
                        rr_ptr <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    end
                end
                CALC: begin
                    m_q   <= m_next;
                    res_q <= res_next;
                    bit_q <= bit_q >> 2;
                    cnt_q <= cnt_q - 1'b1;
                    if (last_iter) begin
                        res_valid <= 1'b1;
                        res_data  <= res_next[RES_W-1:0];
                        res_id    <= id_q;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_root_norm_sched.sv
// Self-checking bench for root_norm_sched: random radicands and request masks against
// an integer-search square root and a round-robin reference model.
module tb_root_norm_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = '0;
    logic [127:0] req_data = '0;
    logic         res_ready = 1'b1;
    logic [3:0]   gnt;
    logic         res_valid;
    logic [15:0]  res_data;
    logic [1:0]   res_id;
    logic         busy;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    root_norm_sched #(
        .NUM_REQ (4),
        .DATA_W  (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    // Largest r with r*r <= x, found by binary search.
    function automatic longint isqrt(input longint x);
        longint lo, hi, mid;
        lo = 0;
        hi = 65536;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= x) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    function automatic int rr_pick(input int ptr, input logic [3:0] mask);
        for (int k = 0; k < 4; k++) begin
            if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req = '0;
        res_ready = 1'b1;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic run_job(input int idx, input logic [31:0] data, output logic [3:0] g,
                           output int lat, output logic [15:0] r, output logic [1:0] rid);
        req_data[idx*32 +: 32] = data;
        req = 4'(1 << idx);
        #1;
        g = gnt;
        tick;
        req = '0;
        lat = 1;
        while (!res_valid && lat < 40) begin
            tick;
            lat++;
        end
        r = res_data;
        rid = res_id;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req = 4'hF;
        res_ready = 1'b1;
        tick;
        #1;
        n_cmp++; if (gnt !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); end
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", res_valid); end
        n_cmp++; if (res_data !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_data: got %h expected 0", res_data); end
        n_cmp++; if (res_id !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_id: got %0d expected 0", res_id); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        req = '0;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        int lat;
        req_data[64 +: 32] = 32'd1000000;
        req = 4'b0100;
        #1;
        n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("[TB] FAIL single_gnt: got %b expected 0100", gnt); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL single_busy_grant: got %b expected 0", busy); end
        tick;
        req = '0;
        #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL single_gnt_pulse: got %b expected 0000", gnt); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL single_busy_calc: got %b expected 1", busy); end
        lat = 1;
        while (!res_valid && lat < 40) begin
            tick;
            lat++;
        end
        n_cmp++; if (lat !== 17) begin n_fail++; $display("[TB] FAIL single_latency: got %0d expected 17", lat); end
        n_cmp++; if (res_data !== 16'(isqrt(1000000))) begin n_fail++; $display("[TB] FAIL single_data: got %0d expected %0d", res_data, isqrt(1000000)); end
        n_cmp++; if (res_id !== 2'd2) begin n_fail++; $display("[TB] FAIL single_id: got %0d expected 2", res_id); end
        tick;
        n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL single_release: got valid=%b busy=%b expected 0 0", res_valid, busy); end
    endtask

    task automatic test_boundary;
        logic [31:0] vals [13];
        logic [3:0]  g;
        logic [15:0] r;
        logic [1:0]  rid;
        logic [31:0] root;
        int          lat;
        vals[0] = 32'd0;
        vals[1] = 32'd1;
        vals[2] = 32'd2;
        vals[3] = 32'd15;
        vals[4] = 32'd16;
        vals[5] = 32'd65535;
        vals[6] = 32'hFFFF_FFFF;
        for (int i = 7; i < 10; i++) vals[i] = $urandom;
        for (int i = 10; i < 13; i++) begin
            root = 32'($urandom_range(0, 65535));
            vals[i] = root * root;
        end
        for (int i = 0; i < 13; i++) begin
            run_job(0, vals[i], g, lat, r, rid);
            n_cmp++; if (g !== 4'b0001) begin n_fail++; $display("[TB] FAIL bound_gnt[%0d]: got %b expected 0001", i, g); end
            n_cmp++; if (lat !== 17) begin n_fail++; $display("[TB] FAIL bound_latency[%0d]: got %0d expected 17", i, lat); end
            n_cmp++; if (r !== 16'(isqrt(longint'(vals[i])))) begin n_fail++; $display("[TB] FAIL bound_data[%0d]: sqrt(%0d) got %0d expected %0d", i, vals[i], r, isqrt(longint'(vals[i]))); end
            n_cmp++; if (rid !== 2'd0) begin n_fail++; $display("[TB] FAIL bound_id[%0d]: got %0d expected 0", i, rid); end
        end
    endtask

    task automatic test_round_robin;
        logic [31:0] data [4];
        int ptr, grants, last_t, cur, exp_i, n;
        data[0] = 32'd4;
        data[1] = 32'd9;
        data[2] = 32'd25;
        data[3] = 32'd49;
        do_reset;
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = data[i];
        req = 4'hF;
        ptr = 0;
        grants = 0;
        last_t = -1;
        cur = 0;
        for (int t = 0; t < 150; t++) begin
            #1;
            if (gnt !== 4'h0) begin
                exp_i = rr_pick(ptr, 4'hF);
                n_cmp++; if (gnt !== 4'(1 << exp_i)) begin n_fail++; $display("[TB] FAIL rr_grant[%0d]: got %b expected id %0d", grants, gnt, exp_i); end
                if (last_t >= 0) begin
                    n_cmp++; if (t - last_t !== 18) begin n_fail++; $display("[TB] FAIL rr_interval[%0d]: got %0d expected 18", grants, t - last_t); end
                end
                last_t = t;
                ptr = (exp_i + 1) % 4;
                cur = exp_i;
                grants++;
            end
            if (res_valid) begin
                n_cmp++; if (res_id !== 2'(cur)) begin n_fail++; $display("[TB] FAIL rr_id: got %0d expected %0d", res_id, cur); end
                n_cmp++; if (res_data !== 16'(isqrt(longint'(data[cur])))) begin n_fail++; $display("[TB] FAIL rr_data: got %0d expected %0d", res_data, isqrt(longint'(data[cur]))); end
            end
            if (grants == 5) break;
            tick;
        end
        n_cmp++; if (grants !== 5) begin n_fail++; $display("[TB] FAIL rr_grant_count: got %0d expected 5", grants); end
        req = '0;
        n = 0;
        while (busy && n < 40) begin
            tick;
            n++;
        end
    endtask

    task automatic test_random;
        logic [31:0] data [4];
        logic [3:0]  mask;
        logic [15:0] rt;
        int ptr, grants, results, cur, gnt_t, exp_i;
        bit pending, seen;
        do_reset;
        mask = 4'($urandom_range(1, 15));
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                rt = 16'($urandom);
                data[i] = {16'h0, rt} * {16'h0, rt};
            end else begin
                data[i] = $urandom;
            end
            req_data[i*32 +: 32] = data[i];
        end
        req = mask;
        ptr = 0;
        grants = 0;
        results = 0;
        cur = 0;
        gnt_t = 0;
        pending = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            res_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (gnt !== 4'h0) begin
                exp_i = rr_pick(ptr, mask);
                n_cmp++; if (gnt !== 4'(1 << exp_i)) begin n_fail++; $display("[TB] FAIL rnd_grant[%0d]: got %b expected id %0d mask %b", grants, gnt, exp_i, mask); end
                n_cmp++; if (pending !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_gnt_while_held: got pending=%b busy=%b expected 0 0", pending, busy); end
                ptr = (exp_i + 1) % 4;
                cur = exp_i;
                gnt_t = t;
                pending = 1'b1;
                seen = 1'b0;
                grants++;
            end
            if (res_valid) begin
                if (!seen) begin
                    n_cmp++; if (t - gnt_t !== 17) begin n_fail++; $display("[TB] FAIL rnd_latency: got %0d expected 17", t - gnt_t); end
                    seen = 1'b1;
                end
                n_cmp++; if (res_id !== 2'(cur)) begin n_fail++; $display("[TB] FAIL rnd_id: got %0d expected %0d", res_id, cur); end
                n_cmp++; if (res_data !== 16'(isqrt(longint'(data[cur])))) begin n_fail++; $display("[TB] FAIL rnd_data: got %0d expected %0d", res_data, isqrt(longint'(data[cur]))); end
                if (res_ready) begin
                    pending = 1'b0;
                    results++;
                end
            end
            if (grants == 8 && !pending) break;
            tick;
        end
        req = '0;
        res_ready = 1'b1;
        n_cmp++; if (results !== 8) begin n_fail++; $display("[TB] FAIL rnd_result_count: got %0d expected 8", results); end
        tick;
        tick;
    endtask

    task automatic test_backpressure;
        logic [31:0] d0, d1;
        int lat;
        do_reset;
        d0 = $urandom | 32'h100;
        d1 = $urandom;
        req_data[0 +: 32] = d0;
        req_data[32 +: 32] = d1;
        res_ready = 1'b0;
        req = 4'b0011;
        #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("[TB] FAIL bp_first_gnt: got %b expected 0001", gnt); end
        tick;
        req = 4'b0010;
        lat = 1;
        while (!res_valid && lat < 40) begin
            tick;
            lat++;
        end
        n_cmp++; if (lat !== 17) begin n_fail++; $display("[TB] FAIL bp_latency: got %0d expected 17", lat); end
        for (int i = 0; i < 10; i++) begin
            #1;
            n_cmp++; if (res_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_hold[%0d]: got valid=%b busy=%b expected 1 1", i, res_valid, busy); end
            n_cmp++; if (res_data !== 16'(isqrt(longint'(d0))) || res_id !== 2'd0) begin n_fail++; $display("[TB] FAIL bp_hold_data[%0d]: got %0d id %0d expected %0d id 0", i, res_data, res_id, isqrt(longint'(d0))); end
            n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL bp_no_gnt[%0d]: got %b expected 0000", i, gnt); end
            tick;
        end
        res_ready = 1'b1;
        #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL bp_accept_gnt: got %b expected 0000", gnt); end
        tick;
        #1;
        n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("[TB] FAIL bp_next_gnt: got %b expected 0010", gnt); end
        n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_idle: got valid=%b busy=%b expected 0 0", res_valid, busy); end
        tick;
        req = '0;
        lat = 1;
        while (!res_valid && lat < 40) begin
            tick;
            lat++;
        end
        n_cmp++; if (res_id !== 2'd1 || res_data !== 16'(isqrt(longint'(d1)))) begin n_fail++; $display("[TB] FAIL bp_second: got %0d id %0d expected %0d id 1", res_data, res_id, isqrt(longint'(d1))); end
        tick;
    endtask

    task automatic test_reset_mid_calc;
        logic [3:0]  g;
        logic [15:0] r;
        logic [1:0]  rid;
        int          lat, vcount;
        logic [31:0] d;
        req_data[64 +: 32] = $urandom;
        req = 4'b0100;
        #1;
        n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("[TB] FAIL mid_gnt: got %b expected 0100", gnt); end
        tick;
        req = '0;
        repeat (4) tick;
        rst_n = 1'b0;
        tick;
        #1;
        n_cmp++; if (gnt !== 4'h0 || res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_ctrl: got gnt=%b valid=%b busy=%b expected all 0", gnt, res_valid, busy); end
        n_cmp++; if (res_data !== 16'h0 || res_id !== 2'd0) begin n_fail++; $display("[TB] FAIL mid_reset_data: got data=%0d id=%0d expected 0 0", res_data, res_id); end
        rst_n = 1'b1;
        vcount = 0;
        for (int t = 0; t < 30; t++) begin
            tick;
            if (res_valid) vcount++;
        end
        n_cmp++; if (vcount !== 0) begin n_fail++; $display("[TB] FAIL mid_no_result: got %0d valid cycles expected 0", vcount); end
        d = $urandom;
        req_data[96 +: 32] = $urandom;
        req_data[0 +: 32] = d;
        req = 4'b1001;
        #1;
        g = gnt;
        n_cmp++; if (g !== 4'b0001) begin n_fail++; $display("[TB] FAIL mid_post_gnt: got %b expected 0001", g); end
        tick;
        req = '0;
        lat = 1;
        while (!res_valid && lat < 40) begin
            tick;
            lat++;
        end
        r = res_data;
        rid = res_id;
        n_cmp++; if (rid !== 2'd0 || r !== 16'(isqrt(longint'(d)))) begin n_fail++; $display("[TB] FAIL mid_post_result: got %0d id %0d expected %0d id 0", r, rid, isqrt(longint'(d))); end
        tick;
    endtask

    task automatic test_withdrawn;
        logic [31:0] d0, d3;
        bit g3seen;
        int g1, id1, res3;
        do_reset;
        d0 = $urandom;
        d3 = $urandom;
        req_data[0 +: 32] = d0;
        req_data[96 +: 32] = d3;
        req = 4'b0001;
        #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("[TB] FAIL wd_first_gnt: got %b expected 0001", gnt); end
        tick;
        g3seen = 1'b0;
        g1 = 0;
        id1 = 0;
        res3 = 0;
        for (int t = 0; t < 80; t++) begin
            req = (t < 4) ? 4'b1010 : (g3seen ? 4'b0000 : 4'b1000);
            #1;
            if (gnt[1]) g1++;
            if (gnt !== 4'h0 && !gnt[1]) begin
                n_cmp++; if (gnt !== 4'(1 << rr_pick(1, req))) begin n_fail++; $display("[TB] FAIL wd_gnt: got %b expected 1000", gnt); end
                g3seen = 1'b1;
            end
            if (res_valid) begin
                if (res_id === 2'd1) id1++;
                if (g3seen) begin
                    n_cmp++; if (res_id !== 2'd3 || res_data !== 16'(isqrt(longint'(d3)))) begin n_fail++; $display("[TB] FAIL wd_res3: got %0d id %0d expected %0d id 3", res_data, res_id, isqrt(longint'(d3))); end
                    res3++;
                end else begin
                    n_cmp++; if (res_id !== 2'd0 || res_data !== 16'(isqrt(longint'(d0)))) begin n_fail++; $display("[TB] FAIL wd_res0: got %0d id %0d expected %0d id 0", res_data, res_id, isqrt(longint'(d0))); end
                end
            end
            tick;
            if (res3 > 0) break;
        end
        req = '0;
        n_cmp++; if (g1 !== 0) begin n_fail++; $display("[TB] FAIL wd_gnt1: got %0d grants expected 0", g1); end
        n_cmp++; if (id1 !== 0) begin n_fail++; $display("[TB] FAIL wd_id1: got %0d results expected 0", id1); end
        n_cmp++; if (res3 !== 1) begin n_fail++; $display("[TB] FAIL wd_res3_count: got %0d expected 1", res3); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting root_norm_sched bench");
        test_reset;
        test_single;
        test_boundary;
        test_round_robin;
        test_random;
        test_backpressure;
        test_reset_mid_calc;
        test_withdrawn;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
